// File: rtl/dwt_pkg.sv
// Shared types and predict arithmetic for the LeGall 5/3 lifting datapath.
// Optional macro PREDICTOR_SAT_EN: saturate the detail coefficient instead of wrapping.
package dwt_pkg;

   localparam int DATA_W = 16;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic signed [DATA_W-1:0] coef_t;

   localparam logic signed [DATA_W+1:0] COEF_MAX = (2 ** (DATA_W - 1)) - 1;
   localparam logic signed [DATA_W+1:0] COEF_MIN = -(2 ** (DATA_W - 1));

   // d = odd - floor((left + right) / 2), computed without intermediate overflow.
   function automatic coef_t predict_fn(sample_t odd, sample_t left, sample_t right);
      logic signed [DATA_W:0]   sum;
      logic signed [DATA_W:0]   half;
      logic signed [DATA_W+1:0] diff;
      sum  = $signed({left[DATA_W-1], left}) + $signed({right[DATA_W-1], right});
      half = sum >>> 1;
      diff = $signed({{2{odd[DATA_W-1]}}, odd}) - $signed({half[DATA_W], half});
`ifdef PREDICTOR_SAT_EN
      if (diff > COEF_MAX) begin
         return COEF_MAX[DATA_W-1:0];
      end else if (diff < COEF_MIN) begin
         return COEF_MIN[DATA_W-1:0];
      end else begin
         return diff[DATA_W-1:0];
      end
`else
      return diff[DATA_W-1:0];
`endif
   endfunction

endpackage

// File: rtl/predictor_if.sv
// Sample stream and detail output bundle between splitter, predictor and update stage.
interface predictor_if #(parameter int DATA_W = dwt_pkg::DATA_W);
   logic signed [DATA_W-1:0] data;
   logic                     valid_in;
   logic                     iseven;
   logic                     internal_valid;
   logic                     valid_detailOut;
   logic signed [DATA_W-1:0] detail_coefficient;

   modport master (
      output data, valid_in, iseven, internal_valid, valid_detailOut,
      input  detail_coefficient
   );

   modport slave (
      input  data, valid_in, iseven, internal_valid, valid_detailOut,
      output detail_coefficient
   );
endinterface

// File: rtl/predict_alu.sv
// Combinational predict arithmetic: odd sample minus floor of the neighbouring even average.
module predict_alu
   import dwt_pkg::*;
(
   input  sample_t odd,
   input  sample_t left,
   input  sample_t right,
   output coef_t   coef
);
   assign coef = predict_fn(odd, left, right);
endmodule

// File: rtl/predictor.sv
// LeGall 5/3 predict stage: one registered detail coefficient per completed even/odd/even triple.
// Optional macro PREDICTOR_SAT_EN selects a saturating difference (default wraps).
module predictor
   import dwt_pkg::*;
#(
   parameter int DATA_W = dwt_pkg::DATA_W
) (
   input  logic        clk,
   input  logic        rst,
   predictor_if.slave  bus
);

   logic signed [DATA_W-1:0] even_reg;
   logic signed [DATA_W-1:0] odd_reg;
   logic signed [DATA_W-1:0] coef_reg;
   logic signed [DATA_W-1:0] right_even;
   logic signed [DATA_W-1:0] alu_coef;
   logic                     have_even;
   logic                     have_odd;
   logic                     even_in;
   logic                     odd_in;
   logic                     pair_ready;
   logic                     emit_even;
   logic                     emit_boundary;

   assign even_in       = bus.valid_in & bus.iseven;
   assign odd_in        = bus.valid_in & ~bus.iseven;
   assign pair_ready    = bus.valid_detailOut & have_even & have_odd;
   assign emit_even     = even_in & pair_ready;
   assign emit_boundary = ~even_in & bus.internal_valid & pair_ready;

   // At a row end the missing right neighbour mirrors the left one.
   assign right_even = even_in ? bus.data : even_reg;

   predict_alu u_alu (
      .odd   (odd_reg),
      .left  (even_reg),
      .right (right_even),
      .coef  (alu_coef)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         even_reg  <= '0;
         odd_reg   <= '0;
         coef_reg  <= '0;
         have_even <= 1'b0;
         have_odd  <= 1'b0;
      end else begin
         if (emit_even || emit_boundary) begin
            coef_reg <= alu_coef;
            have_odd <= 1'b0;
         end
         if (emit_boundary) begin
            have_even <= 1'b0;
         end
         if (even_in) begin
            even_reg  <= bus.data;
            have_even <= 1'b1;
         end
         // A newer odd sample replaces any unconsumed one.
         if (odd_in) begin
            odd_reg  <= bus.data;
            have_odd <= 1'b1;
         end
      end
   end

   assign bus.detail_coefficient = coef_reg;

endmodule

// File: tb/tb_predictor.sv
// Self-checking bench for the predict stage: directed vector table plus randomized model comparison.
module tb_predictor;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   predictor_if #(.DATA_W(16)) bus ();

   predictor #(.DATA_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string      name;
      logic       rst_n;
      logic       vin;
      logic       even;
      logic       iv;
      logic       vdo;
      logic [15:0] data;
      logic [15:0] expect_out;
   } vec_t;

`ifdef PREDICTOR_SAT_EN
   localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
   localparam logic [15:0] OVF_EXP = 16'hFFFF;
`endif

   vec_t vecs[$];

   // Reference model state: the last unconsumed even and odd samples.
   int   m_left, m_odd;
   bit   m_has_left, m_has_odd;
   logic [15:0] m_out;

   function automatic int to_int(logic [15:0] v);
      return $signed(v);
   endfunction

   function automatic int floor_half(int s);
      return (s >= 0) ? s / 2 : -((-s + 1) / 2);
   endfunction

   function automatic logic [15:0] reduce(int d);
`ifdef PREDICTOR_SAT_EN
      if (d > 32767) d = 32767;
      if (d < -32768) d = -32768;
`endif
      return 16'(d);
   endfunction

   task automatic model_step(logic rst_n, logic vin, logic ev, logic iv, logic vdo, logic [15:0] d);
      if (!rst_n) begin
         m_has_left = 0;
         m_has_odd  = 0;
         m_out      = 16'h0000;
      end else if (vin && ev) begin
         if (vdo && m_has_left && m_has_odd) begin
            m_out     = reduce(m_odd - floor_half(m_left + to_int(d)));
            m_has_odd = 0;
         end
         m_left     = to_int(d);
         m_has_left = 1;
      end else begin
         if (iv && vdo && m_has_left && m_has_odd) begin
            m_out      = reduce(m_odd - m_left);
            m_has_odd  = 0;
            m_has_left = 0;
         end
         if (vin) begin
            m_odd     = to_int(d);
            m_has_odd = 1;
         end
      end
   endtask

   task automatic drive(logic rst_n, logic vin, logic ev, logic iv, logic vdo, logic [15:0] d);
      rst                 = rst_n;
      bus.valid_in        = vin;
      bus.iseven          = ev;
      bus.internal_valid  = iv;
      bus.valid_detailOut = vdo;
      bus.data            = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [15:0] required);
      n_tests++;
      if (bus.detail_coefficient !== required) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, required 0x%04h", name, bus.detail_coefficient, required);
      end
   endtask

   task automatic add(string nm, logic r, logic v, logic e, logic i, logic o, logic [15:0] d, logic [15:0] x);
      vec_t t;
      t.name = nm; t.rst_n = r; t.vin = v; t.even = e; t.iv = i; t.vdo = o;
      t.data = d; t.expect_out = x;
      vecs.push_back(t);
   endtask

   initial begin
      bus.data = '0; bus.valid_in = 0; bus.iseven = 0;
      bus.internal_valid = 0; bus.valid_detailOut = 0;

      //   name           rst v  e  iv vdo data      expected
      add("reset0",        0, 1, 1, 1, 1, 16'hA5A5, 16'h0000);
      add("reset1",        0, 1, 0, 1, 1, 16'h5A5A, 16'h0000);
      add("basic_e0",      1, 1, 1, 0, 1, 16'h1111, 16'h0000);
      add("basic_o",       1, 1, 0, 0, 1, 16'h2222, 16'h0000);
      add("basic_e1",      1, 1, 1, 0, 1, 16'h3333, 16'h0000);
      add("floor_e0",      1, 1, 1, 0, 1, 16'h0001, 16'h0000);
      add("floor_o",       1, 1, 0, 0, 1, 16'h0000, 16'h0000);
      add("floor_e1",      1, 1, 1, 0, 1, 16'h0000, 16'h0000);
      add("neg_o",         1, 1, 0, 0, 1, 16'hFFFF, 16'h0000);
      add("neg_e",         1, 1, 1, 0, 1, 16'h0003, 16'hFFFE);
      add("gate_e0",       1, 1, 1, 0, 0, 16'h0010, 16'hFFFE);
      add("gate_o",        1, 1, 0, 0, 0, 16'h0030, 16'hFFFE);
      add("gate_e1",       1, 1, 1, 0, 0, 16'h0020, 16'hFFFE);
      add("gate_bound",    1, 0, 0, 1, 1, 16'h0000, 16'h0010);
      add("ovf_e0",        1, 1, 1, 0, 1, 16'h8000, 16'h0010);
      add("ovf_o",         1, 1, 0, 0, 1, 16'h7FFF, 16'h0010);
      add("ovf_e1",        1, 1, 1, 0, 1, 16'h8000, OVF_EXP);
      add("prio_e0",       1, 1, 1, 0, 1, 16'h0040, OVF_EXP);
      add("prio_o",        1, 1, 0, 0, 1, 16'h0070, OVF_EXP);
      add("prio_e_iv",     1, 1, 1, 1, 1, 16'h0060, 16'h0020);
      add("bound_noodd",   1, 0, 0, 1, 1, 16'h0000, 16'h0020);
      add("drop_o0",       1, 1, 0, 0, 1, 16'h0001, 16'h0020);
      add("drop_o1",       1, 1, 0, 0, 1, 16'h0100, 16'h0020);
      add("drop_e",        1, 1, 1, 0, 1, 16'h0020, 16'h00C0);
      add("mid_e",         1, 1, 1, 0, 1, 16'h1111, 16'h00C0);
      add("mid_o",         1, 1, 0, 0, 1, 16'h2222, 16'h00C0);
      add("mid_rst",       0, 0, 0, 0, 1, 16'h0000, 16'h0000);
      add("mid_after",     1, 1, 1, 0, 1, 16'h1234, 16'h0000);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_n, vecs[i].vin, vecs[i].even, vecs[i].iv, vecs[i].vdo, vecs[i].data);
         check(vecs[i].name, vecs[i].expect_out);
      end

      // Randomized phase against the reference model, starting from reset.
      drive(0, 0, 0, 0, 0, 16'h0000);
      model_step(0, 0, 0, 0, 0, 16'h0000);
      check("rand_reset", m_out);
      for (int i = 0; i < 400; i++) begin
         logic r, v, e, iv, o;
         logic [15:0] d;
         r  = ($urandom_range(0, 49) != 0);
         v  = ($urandom_range(0, 9) < 8);
         e  = $urandom_range(0, 1);
         iv = ($urandom_range(0, 9) == 0);
         o  = ($urandom_range(0, 9) < 7);
         d  = ($urandom_range(0, 7) == 0) ? 16'h8000 | 16'($urandom_range(0, 3))
                                          : 16'($urandom);
         drive(r, v, e, iv, o, d);
         model_step(r, v, e, iv, o, d);
         check("rand", m_out);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
